// File: rtl/store_rmw_unit.sv
// store_rmw_unit: sequenced byte/halfword/word store into word-organised memory via read-modify-write
module store_rmw_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        command,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              misaligned,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int LB = $clog2(DATA_W / 8);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state;
  logic [2:0] cnt;
  logic [1:0] cmd;
  logic [ADDR_W-1:0] a, aligned;
  logic [DATA_W-1:0] wd, rd, mask, ins, merged;
  logic mis, s_byte, s_half, bad;
  logic [LB+2:0] sh;
  assign s_byte = command == 2'b01;
  assign s_half = command == 2'b10;
  assign bad = (s_half & addr[0]) | (!s_half & !s_byte & |addr[LB-1:0]);
  assign aligned = {a[ADDR_W-1:LB], {LB{1'b0}}};
  assign sh = {a[LB-1:0], 3'b000};
  always_comb begin
    mask = (cmd == 2'b01 ? DATA_W'(8'hff) : DATA_W'(16'hffff)) << sh;
    ins = (cmd == 2'b01 ? DATA_W'(wd[7:0]) : DATA_W'(wd[15:0])) << sh;
    merged = (cmd == 2'b01 || cmd == 2'b10) ? (rd & ~mask) | ins : wd;
  end
  assign busy = state == READ || state == WRITE;
  assign done = state == DONE;
  assign misaligned = done & mis;
  assign mem_rd = state == READ;
  assign mem_wr = state == WRITE;
  assign mem_addr = busy ? aligned : '0;
  assign mem_wdata = mem_wr ? merged : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      cmd <= '0;
      a <= '0;
      wd <= '0;
      rd <= '0;
      mis <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cmd <= command;
          a <= addr;
          wd <= wdata;
          mis <= bad;
          cnt <= 3'(RD_LAT);
          state <= bad ? DONE : (s_byte | s_half) ? READ : WRITE;
        end
        READ: if (cnt == 3'd1) begin
          rd <= mem_rdata;
          state <= WRITE;
        end else cnt <= cnt - 3'd1;
        WRITE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_store_rmw_unit.sv
// tb_store_rmw_unit: randomized store sequences checked against a byte-array memory model
module tb_store_rmw_unit;
  typedef struct packed {
    logic [7:0] rd_first, rd_n, wr_c, wr_n, done_c, done_n;
    logic mis, bad;
    logic [31:0] wr_d, wr_a, rd_a;
  } obs_t;
  logic clk = 0, reset = 1, start = 0, sel = 0;
  logic [1:0] command = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic b1, d1, m1, r1, w1, b3, d3, m3, r3, w3;
  logic [31:0] a1, wd1, rd1, a3, wd3, rd3;
  logic busy, done, misaligned, mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem [256];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign rd1 = mem[a1[9:2]];
  assign rd3 = mem[a3[9:2]];
  store_rmw_unit #(.DATA_W(32), .ADDR_W(32), .RD_LAT(1)) u1 (
    .clk(clk), .reset(reset), .start(start & ~sel), .command(command), .addr(addr), .wdata(wdata),
    .busy(b1), .done(d1), .misaligned(m1), .mem_addr(a1), .mem_rd(r1), .mem_wr(w1),
    .mem_wdata(wd1), .mem_rdata(rd1));
  store_rmw_unit #(.DATA_W(32), .ADDR_W(32), .RD_LAT(3)) u3 (
    .clk(clk), .reset(reset), .start(start & sel), .command(command), .addr(addr), .wdata(wdata),
    .busy(b3), .done(d3), .misaligned(m3), .mem_addr(a3), .mem_rd(r3), .mem_wr(w3),
    .mem_wdata(wd3), .mem_rdata(rd3));
  assign busy = sel ? b3 : b1;
  assign done = sel ? d3 : d1;
  assign misaligned = sel ? m3 : m1;
  assign mem_rd = sel ? r3 : r1;
  assign mem_wr = sel ? w3 : w1;
  assign mem_addr = sel ? a3 : a1;
  assign mem_wdata = sel ? wd3 : wd1;

  function automatic int size_of(input logic [1:0] cmd);
    return cmd == 2'b01 ? 1 : cmd == 2'b10 ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] old, input logic [1:0] cmd,
                                             input logic [31:0] a, input logic [31:0] wd);
    logic [7:0] b [4];
    int k;
    if (size_of(cmd) == 4) return wd;
    for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
    k = int'(a[1:0]);
    b[k] = wd[7:0];
    if (size_of(cmd) == 2 && k < 3) b[k+1] = wd[15:8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  function automatic obs_t expect_store(input int lat, input logic [1:0] cmd, input logic [31:0] a,
                                        input logic [31:0] wd, input logic [31:0] old);
    obs_t e = '0;
    int sz = size_of(cmd);
    e.done_n = 8'd1;
    if ((a & 32'(sz - 1)) != 0) begin
      e.done_c = 8'd1;
      e.mis = 1'b1;
    end else begin
      e.wr_n = 8'd1;
      e.wr_a = a & ~32'h3;
      e.wr_d = model_word(old, cmd, a, wd);
      if (sz == 4) begin
        e.wr_c = 8'd1;
        e.done_c = 8'd2;
      end else begin
        e.rd_first = 8'd1;
        e.rd_n = 8'(lat);
        e.rd_a = e.wr_a;
        e.wr_c = 8'(lat + 1);
        e.done_c = 8'(lat + 2);
      end
    end
    return e;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("rd=%0d@%0d ra=%h wr=%0d@%0d wd=%h wa=%h done=%0d@%0d mis=%b bad=%b",
      o.rd_n, o.rd_first, o.rd_a, o.wr_n, o.wr_c, o.wr_d, o.wr_a, o.done_n, o.done_c, o.mis, o.bad);
  endfunction

  // Issue one store in cycle 0 and observe 12 following cycles; g re-strobes start, r pulses reset.
  task automatic drive_store(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] wd,
                             input int g, input int r, output obs_t o);
    o = '0;
    command = cmd;
    addr = a;
    wdata = wd;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    command = 2'($urandom);
    addr = $urandom;
    wdata = $urandom;
    for (int c = 1; c <= 12; c++) begin
      if (mem_rd) begin
        if (o.rd_n == 0) begin
          o.rd_first = 8'(c);
          o.rd_a = mem_addr;
        end else if (mem_addr !== o.rd_a) o.bad = 1'b1;
        o.rd_n += 8'd1;
      end
      if (mem_wr) begin
        o.wr_c = 8'(c);
        o.wr_n += 8'd1;
        o.wr_d = mem_wdata;
        o.wr_a = mem_addr;
        mem[mem_addr[9:2]] = mem_wdata;
      end
      if (done) begin
        o.done_c = 8'(c);
        o.done_n += 8'd1;
        o.mis = misaligned;
      end
      if (busy !== (mem_rd | mem_wr) || (mem_rd && mem_wr) || (!busy && mem_addr !== 0) ||
          (!mem_wr && mem_wdata !== 0) || (misaligned && !done)) o.bad = 1'b1;
      start = c == g;
      if (c == g) begin
        command = 2'($urandom);
        addr = $urandom_range(0, 1023);
        wdata = $urandom;
      end
      reset = c == r;
      @(posedge clk); #1;
    end
    start = 0;
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({b1, d1, m1, r1, w1, a1, wd1} !== '0) begin
      errors++;
      $display("FAIL reset_lat1: got %h want 0", {b1, d1, m1, r1, w1, a1, wd1});
    end
    reset = 0;
    @(posedge clk); #1;
    checks++;
    if ({b3, d3, m3, r3, w3, a3, wd3} !== '0) begin
      errors++;
      $display("FAIL reset_lat3: got %h want 0", {b3, d3, m3, r3, w3, a3, wd3});
    end
  endtask

  task automatic test_byte();
    obs_t o, e;
    sel = 0;
    mem[8'h40] = 32'hAABBCCDD;
    e = expect_store(1, 2'b01, 32'h102, 32'h12345678, 32'hAABBCCDD);
    drive_store(2'b01, 32'h102, 32'h12345678, 0, 0, o);
    checks++;
    if (o !== e) begin errors++; $display("FAIL byte: got %s want %s", fmt(o), fmt(e)); end
    checks++;
    if (o.wr_d !== 32'hAA78CCDD || o.wr_c !== 8'd2 || o.done_c !== 8'd3) begin
      errors++;
      $display("FAIL byte_plan: got %s want wd=aa78ccdd@2 done@3", fmt(o));
    end
  endtask

  task automatic test_halfword();
    obs_t o, e;
    logic [31:0] want [2] = '{32'hBEEF3344, 32'h1122BEEF};
    logic [31:0] at [2] = '{32'h206, 32'h204};
    sel = 0;
    for (int i = 0; i < 2; i++) begin
      mem[8'h81] = 32'h11223344;
      e = expect_store(1, 2'b10, at[i], 32'hDEADBEEF, 32'h11223344);
      drive_store(2'b10, at[i], 32'hDEADBEEF, 0, 0, o);
      checks++;
      if (o !== e) begin errors++; $display("FAIL half_%0d: got %s want %s", i, fmt(o), fmt(e)); end
      checks++;
      if (o.wr_d !== want[i] || o.wr_a !== 32'h204) begin
        errors++;
        $display("FAIL half_plan_%0d: got wd=%h wa=%h want wd=%h wa=00000204", i, o.wr_d, o.wr_a, want[i]);
      end
    end
  endtask

  task automatic test_word();
    obs_t o, e;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      e = expect_store(s ? 3 : 1, 2'b11, 32'h300, 32'hCAFEF00D, mem[8'hC0]);
      drive_store(s[0] ? 2'b11 : 2'b00, 32'h300, 32'hCAFEF00D, 0, 0, o);
      checks++;
      if (o !== e) begin errors++; $display("FAIL word_%0d: got %s want %s", s, fmt(o), fmt(e)); end
      checks++;
      if (o.rd_n !== 8'd0 || o.wr_c !== 8'd1 || o.wr_d !== 32'hCAFEF00D || o.done_c !== 8'd2) begin
        errors++;
        $display("FAIL word_plan_%0d: got %s want no read, wd=cafef00d@1 done@2", s, fmt(o));
      end
    end
  endtask

  task automatic test_misaligned();
    obs_t o, e;
    logic [1:0] cm [4] = '{2'b10, 2'b11, 2'b00, 2'b10};
    logic [31:0] at [4] = '{32'h101, 32'h302, 32'h201, 32'h3FF};
    for (int i = 0; i < 4; i++) begin
      sel = i[0];
      e = expect_store(i[0] ? 3 : 1, cm[i], at[i], 32'h5555AAAA, 32'h0);
      drive_store(cm[i], at[i], 32'h5555AAAA, 0, 0, o);
      checks++;
      if (o !== e || o.mis !== 1'b1 || o.done_c !== 8'd1) begin
        errors++;
        $display("FAIL misaligned_%0d: got %s want %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_lat3_ignore_start();
    obs_t o, e;
    sel = 1;
    mem[0] = 32'h0;
    e = expect_store(3, 2'b01, 32'h003, 32'h000000FF, 32'h0);
    drive_store(2'b01, 32'h003, 32'h000000FF, 2, 0, o);
    checks++;
    if (o !== e) begin errors++; $display("FAIL lat3: got %s want %s", fmt(o), fmt(e)); end
    checks++;
    if (o.wr_d !== 32'hFF000000 || o.wr_c !== 8'd4 || o.done_c !== 8'd5 || o.done_n !== 8'd1) begin
      errors++;
      $display("FAIL lat3_plan: got %s want wd=ff000000@4 done=1@5", fmt(o));
    end
  endtask

  task automatic test_reset_mid();
    obs_t o, e;
    logic [31:0] old;
    sel = 1;
    mem[8'h10] = 32'h89ABCDEF;
    e = expect_store(3, 2'b01, 32'h041, 32'h77, 32'h89ABCDEF);
    e.rd_n = 8'd1;
    e.wr_n = 8'd0; e.wr_c = 8'd0; e.wr_d = '0; e.wr_a = '0;
    e.done_n = 8'd0; e.done_c = 8'd0;
    drive_store(2'b01, 32'h041, 32'h77, 0, 1, o);
    checks++;
    if (o !== e || mem[8'h10] !== 32'h89ABCDEF) begin
      errors++;
      $display("FAIL reset_in_read: got %s mem=%h want %s mem=89abcdef", fmt(o), mem[8'h10], fmt(e));
    end
    old = mem[8'h10];
    e = expect_store(3, 2'b10, 32'h042, 32'h1234, old);
    drive_store(2'b10, 32'h042, 32'h1234, 0, 0, o);
    checks++;
    if (o !== e) begin errors++; $display("FAIL after_reset: got %s want %s", fmt(o), fmt(e)); end
    sel = 0;
    old = mem[8'h15];
    e = expect_store(1, 2'b01, 32'h055, 32'hA5, old);
    e.done_n = 8'd0; e.done_c = 8'd0;
    drive_store(2'b01, 32'h055, 32'hA5, 0, 2, o);
    checks++;
    if (o !== e) begin errors++; $display("FAIL reset_in_write: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_random();
    obs_t o, e;
    logic [1:0] cmd;
    logic [31:0] a, wd;
    int g;
    for (int i = 0; i < 60; i++) begin
      sel = 1'($urandom);
      cmd = 2'($urandom);
      a = $urandom_range(0, 1023);
      if ($urandom_range(0, 1) == 1) a = a & ~32'(size_of(cmd) - 1);
      wd = $urandom;
      mem[a[9:2]] = $urandom;
      e = expect_store(sel ? 3 : 1, cmd, a, wd, mem[a[9:2]]);
      g = ($urandom_range(0, 2) == 0) ? $urandom_range(1, int'(e.done_c)) : 0;
      drive_store(cmd, a, wd, g, 0, o);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL random_%0d cmd=%b a=%h g=%0d: got %s want %s", i, cmd, a, g, fmt(o), fmt(e));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_byte();
    test_halfword();
    test_word();
    test_misaligned();
    test_lat3_ignore_start();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
